// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and widths for the mips_mem_responder slice
package mips_mem_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: req/ready memory bus (master: req, we, addr, wdata -> ready, rdata, err)
interface mips_mem_responder_if;
  import mips_mem_pkg::*;
  logic req;
  logic we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic ready;
  logic [WORD_W-1:0] rdata;
  logic err;
  modport master(output req, we, addr, wdata, input ready, rdata, err);
  modport slave(input req, we, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/mips_mem_array.sv
// mips_mem_array: DEPTHx32 word store, sync write, registered read (re loads rdata, clr forces 0), shared idx
module mips_mem_array import mips_mem_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
  always_comb rdata_d = re ? (clr ? '0 : mem[idx]) : rdata_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: wait-stated word memory responder (clk, reset_n, bus slave); MIPS_MEM_ALIGN_CHECK_EN enables misalignment err
module mips_mem_responder import mips_mem_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset_n,
  mips_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic idle, take, acc, cur_we, mis, unused_bits;
  logic [AW+1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata, rdata;
  always_comb begin
    idle = state_q == IDLE;
    take = idle && bus.req;
    cur_we = idle ? bus.we : we_q;
    cur_addr = idle ? bus.addr[AW+1:0] : addr_q;
    cur_wdata = idle ? bus.wdata : wdata_q;
    acc = idle ? take && LATENCY == 0 : state_q == WAIT && cnt_q == CNT_W'(1);
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    mis = cur_addr[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    state_d = idle ? (bus.req ? (LATENCY == 0 ? RESP : WAIT) : IDLE)
            : state_q == WAIT ? (cnt_q == CNT_W'(1) ? RESP : WAIT) : IDLE;
    cnt_d = take ? CNT_W'(LATENCY) : state_q == WAIT ? cnt_q - CNT_W'(1) : cnt_q;
    we_d = take ? bus.we : we_q;
    addr_d = take ? bus.addr[AW+1:0] : addr_q;
    wdata_d = take ? bus.wdata : wdata_q;
    ready_d = acc;
    err_d = acc && mis;
    unused_bits = ^{bus.addr[WORD_W-1:AW+2], cur_addr[1:0]};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q <= err_d;
    end
  end
  mips_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .reset_n(reset_n),
    .we(acc && cur_we && !mis),
    .re(acc && (!cur_we || mis)),
    .clr(mis),
    .idx(cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(rdata)
  );
  assign bus.ready = ready_q;
  assign bus.rdata = rdata;
  assign bus.err = err_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: randomized self-checking bench over LATENCY 0/2/3 instances against a word-array model
module tb_mips_mem_responder;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mips_mem_responder_if i0();
  mips_mem_responder_if i2();
  mips_mem_responder_if i3();
  mips_mem_responder #(.DEPTH(64), .LATENCY(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(i0.slave));
  mips_mem_responder #(.DEPTH(64), .LATENCY(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(i2.slave));
  mips_mem_responder #(.DEPTH(64), .LATENCY(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(i3.slave));
  int tests = 0;
  int fails = 0;
  int lat [3] = '{0, 2, 3};
  logic [31:0] mdl [3][64];
  bit known [3][64];
  logic [31:0] prd [3];
  bit prk [3];

  task automatic drive(input int d, input logic r, w, input logic [31:0] a, wd);
    case (d)
      0: begin i0.req = r; i0.we = w; i0.addr = a; i0.wdata = wd; end
      1: begin i2.req = r; i2.we = w; i2.addr = a; i2.wdata = wd; end
      default: begin i3.req = r; i3.we = w; i3.addr = a; i3.wdata = wd; end
    endcase
  endtask

  task automatic get(input int d, output logic r, output logic [31:0] rd, output logic e);
    case (d)
      0: begin r = i0.ready; rd = i0.rdata; e = i0.err; end
      1: begin r = i2.ready; rd = i2.rdata; e = i2.err; end
      default: begin r = i3.ready; rd = i3.rdata; e = i3.err; end
    endcase
  endtask

  // Expected outcome of one access from the memory's rules: word index, alias, misalignment.
  task automatic model(input int d, input logic w, input logic [31:0] a, wd,
                       output logic [31:0] er, output logic ee, output bit chk);
    int idx;
    bit m;
    idx = int'((a / 4) % 64);
    m = ALIGN && (a % 4 != 0);
    ee = m;
    if (m) begin
      prd[d] = 32'h0;
      prk[d] = 1'b1;
    end else if (w) begin
      mdl[d][idx] = wd;
      known[d][idx] = 1'b1;
    end else begin
      prd[d] = mdl[d][idx];
      prk[d] = known[d][idx];
    end
    er = prd[d];
    chk = prk[d];
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      prd[d] = 32'h0;
      prk[d] = 1'b1;
    end
  endtask

  // One request: n = edges from acceptance (inclusive) to ready, -1 on timeout; r2 = ready one cycle later.
  task automatic xact(input int d, input logic w, input logic [31:0] a, wd,
                      output logic [31:0] rd, output logic e, output int n, output logic r2);
    logic r, e2;
    logic [31:0] x;
    @(negedge clk);
    drive(d, 1'b1, w, a, wd);
    @(posedge clk);
    #1;
    drive(d, 1'b1, ~w, $urandom, $urandom);
    n = 1;
    get(d, r, rd, e);
    while (r !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      get(d, r, rd, e);
    end
    if (r !== 1'b1) n = -1;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    get(d, r2, x, e2);
  endtask

  task automatic test_power_on();
    logic r, e;
    logic [31:0] rd;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      get(d, r, rd, e);
      tests++;
      if ({r, e, rd} !== 34'h0) begin
        fails++;
        $display("FAIL power_on[%0d]: ready=%b err=%b rdata=%h, want all 0", d, r, e, rd);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, er;
    logic e, ee, r2;
    bit chk;
    int n;
    model(1, 1, 32'h40, 32'hDEADBEEF, er, ee, chk);
    xact(1, 1, 32'h40, 32'hDEADBEEF, rd, e, n, r2);
    tests++;
    if (n !== 3 || r2 !== 1'b0) begin
      fails++;
      $display("FAIL store_latency: edges=%0d next_ready=%b, want 3 and 0", n, r2);
    end
    model(1, 0, 32'h40, 32'h0, er, ee, chk);
    xact(1, 0, 32'h40, 32'h0, rd, e, n, r2);
    tests++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0 || n !== 3) begin
      fails++;
      $display("FAIL load_0x40: rdata=%h err=%b edges=%0d, want DEADBEEF 0 3", rd, e, n);
    end
  endtask

  task automatic test_reset();
    logic r, e, r2;
    logic [31:0] rd, er;
    logic ee;
    bit chk;
    int n;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    get(1, r, rd, e);
    tests++;
    if ({r, e, rd} !== 34'h0) begin
      fails++;
      $display("FAIL async_reset: ready=%b err=%b rdata=%h, want all 0", r, e, rd);
    end
    reset_model();
    #2;
    reset_n = 1'b1;
    model(1, 0, 32'h40, 32'h0, er, ee, chk);
    xact(1, 0, 32'h40, 32'h0, rd, e, n, r2);
    tests++;
    if (rd !== 32'hDEADBEEF || n !== 3 || r2 !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_load: rdata=%h edges=%0d next=%b, want DEADBEEF 3 0", rd, n, r2);
    end
  endtask

  task automatic test_back_to_back();
    logic r, e;
    logic [31:0] rd, er;
    logic ee;
    bit chk;
    model(0, 1, 32'h0, 32'h11, er, ee, chk);
    @(negedge clk);
    drive(0, 1, 1, 32'h0, 32'h11);
    @(posedge clk);
    #1;
    get(0, r, rd, e);
    tests++;
    if (r !== 1'b1) begin
      fails++;
      $display("FAIL b2b_store_ready: ready=%b, want 1", r);
    end
    model(0, 0, 32'h0, 32'h0, er, ee, chk);
    drive(0, 1, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    get(0, r, rd, e);
    tests++;
    if (r !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: ready=%b, want 0", r);
    end
    @(posedge clk);
    #1;
    get(0, r, rd, e);
    drive(0, 0, 0, 32'h0, 32'h0);
    tests++;
    if (r !== 1'b1 || rd !== 32'h00000011 || rd !== er) begin
      fails++;
      $display("FAIL b2b_load: ready=%b rdata=%h, want 1 00000011", r, rd);
    end
    @(posedge clk);
    #1;
    get(0, r, rd, e);
    tests++;
    if (r !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: ready=%b, want 0", r);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, er;
    logic e, ee, r2;
    bit chk;
    int n;
    model(1, 1, 32'h100, 32'hCAFE0001, er, ee, chk);
    xact(1, 1, 32'h100, 32'hCAFE0001, rd, e, n, r2);
    model(1, 0, 32'h0, 32'h0, er, ee, chk);
    xact(1, 0, 32'h0, 32'h0, rd, e, n, r2);
    tests++;
    if (rd !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL wrap: rdata=%h, want CAFE0001", rd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, er;
    logic e, ee, r2;
    bit chk;
    int n;
    model(1, 1, 32'h42, 32'hFFFFFFFF, er, ee, chk);
    xact(1, 1, 32'h42, 32'hFFFFFFFF, rd, e, n, r2);
    tests++;
    if (e !== ALIGN || n !== 3 || (ALIGN && rd !== 32'h0)) begin
      fails++;
      $display("FAIL misaligned_store: err=%b rdata=%h edges=%0d, want err=%b edges=3", e, rd, n, ALIGN);
    end
    model(1, 0, 32'h40, 32'h0, er, ee, chk);
    xact(1, 0, 32'h40, 32'h0, rd, e, n, r2);
    tests++;
    if (rd !== (ALIGN ? 32'hDEADBEEF : 32'hFFFFFFFF) || e !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_followup: rdata=%h err=%b, want %h 0", rd, e,
               ALIGN ? 32'hDEADBEEF : 32'hFFFFFFFF);
    end
  endtask

  task automatic test_reset_wait();
    logic r, e, r2, saw;
    logic [31:0] rd, er;
    logic ee;
    bit chk;
    int n;
    model(2, 1, 32'h8, 32'hA5A5A5A5, er, ee, chk);
    xact(2, 1, 32'h8, 32'hA5A5A5A5, rd, e, n, r2);
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL lat3_store: edges=%0d, want 4", n);
    end
    @(negedge clk);
    drive(2, 1, 1, 32'h8, 32'h12345678);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive(2, 0, 0, 32'h0, 32'h0);
    reset_n = 1'b0;
    reset_model();
    #2;
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      get(2, r, rd, e);
      if (r !== 1'b0) saw = 1'b1;
    end
    tests++;
    if (saw !== 1'b0) begin
      fails++;
      $display("FAIL reset_wait_ready: saw ready=%b, want 0", saw);
    end
    model(2, 0, 32'h8, 32'h0, er, ee, chk);
    xact(2, 0, 32'h8, 32'h0, rd, e, n, r2);
    tests++;
    if (rd !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL reset_wait_load: rdata=%h, want A5A5A5A5", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, er;
    logic w, e, ee, r2;
    bit chk;
    int d, n;
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      a[7:2] = 6'($urandom_range(0, 15));
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wd = $urandom;
      model(d, w, a, wd, er, ee, chk);
      xact(d, w, a, wd, rd, e, n, r2);
      tests++;
      if (n !== lat[d] + 1 || r2 !== 1'b0) begin
        fails++;
        $display("FAIL rand_timing[%0d]: dut=%0d edges=%0d next=%b, want %0d 0", i, d, n, r2, lat[d] + 1);
      end
      tests++;
      if (e !== ee) begin
        fails++;
        $display("FAIL rand_err[%0d]: dut=%0d addr=%h err=%b, want %b", i, d, a, e, ee);
      end
      if (chk) begin
        tests++;
        if (rd !== er) begin
          fails++;
          $display("FAIL rand_rdata[%0d]: dut=%0d we=%b addr=%h rdata=%h, want %h", i, d, w, a, rd, er);
        end
      end
    end
  endtask

  initial begin
    test_power_on();
    test_store_load();
    test_reset();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the multicycle MIPS controller: a unified instruction/data word memory that serves the controller's fetch, load and store requests over a req/ready handshake with a configurable number of wait states. It sits between the datapath's address mux (PC or ALUOut, selected by i_or_d) and the instruction/data registers. The controller's fetch, load and store states therefore stall on ready instead of assuming single-cycle memory.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 2: wait-state cycles between acceptance and response; range 0–15.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  request valid; level, held by requester until ready.
- we  input  1  1 = store, 0 = load/fetch; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- ready  output  1  one-cycle response pulse.
- rdata  output  32  read data; valid when ready, held until next response.
- err  output  1  misaligned-access flag, valid with ready.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req=1 at a rising edge, latch we/addr/wdata, load the wait counter with LATENCY, and go to WAIT. If LATENCY=0, go directly to RESP.
- WAIT: decrement the counter each cycle. At count 1 → RESP, performing the access on that same edge.
- Access on the edge entering RESP:
  - Load: rdata ← mem[index].
  - Store: mem[index] ← wdata; rdata unchanged.
- RESP: ready=1 for exactly one cycle, then → IDLE unconditionally.
- req is sampled only in IDLE. The requester drops req in the cycle ready is seen. If req is still high in IDLE, it is treated as a new request.
- Index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap (alias).
- Changes to addr/we/wdata after acceptance are ignored.
- Reset values: state IDLE, ready 0, rdata 0, err 0, counter 0. Memory contents are not reset.
- Reset mid-operation (WAIT): the transaction is aborted, no write is committed, and no ready is issued.

## Timing
- Acceptance edge at cycle k. Then:
  - ready high during cycle k+LATENCY+1.
  - rdata/err valid in that same cycle.
- Minimum request spacing: LATENCY+2 cycles (accept, waits, RESP, back in IDLE).
- ready, rdata and err are registered; there is no combinational path from inputs to outputs.

## Configuration
- MIPS_MEM_ALIGN_CHECK_EN defined:
  - An accepted request with addr[1:0]≠0 completes with normal latency.
  - err=1 with ready; store suppressed; rdata ← 0.
  - err=0 on aligned accesses.
- Undefined: addr[1:0] ignored (access rounds down to the word); err tied 0.

## Structure
- Package mips_mem_pkg:
  - state enum (IDLE/WAIT/RESP).
  - WORD_W=32.
  - Counter width constant (4 bits).
- Sub-module mips_mem_array:
  - DEPTH×32 synchronous-write storage.
  - Registered read port, enabled by the responder FSM.
  - Read and write share one index.
- The FSM, counter and alignment check live in the top module.

## Test plan
- Reset: assert reset_n=0 mid-cycle → ready=0, rdata=0, err=0 immediately; FSM in IDLE after release.
- LATENCY=2 store then load:
  - Store 0xDEADBEEF to 0x40 → ready pulses exactly 3 cycles after acceptance, for one cycle.
  - Load 0x40 → rdata=0xDEADBEEF, err=0.
- LATENCY=0 back-to-back (req held high): store 0x11 to 0x0, then load 0x0 → ready every 2nd cycle; load returns 0x00000011.
- Wrap-around (DEPTH=64): store 0xCAFE0001 to 0x100 → load 0x000 returns 0xCAFE0001.
- Misaligned, macro defined: store 0xFFFFFFFF to 0x42 → err=1 with ready; load 0x40 returns its prior value and err=0. Macro undefined: same store writes word 0x40, err=0.
- Reset during WAIT: accept store 0x12345678 to 0x8 (LATENCY=3), pulse reset_n low after 1 cycle → no ready; subsequent load 0x8 returns the prior contents.
